// File: rtl/hash_state_bank.sv
// Chaining/working state bank for SHA-2 style compression: H/W registers, round counting and accumulation.
// Optional serial digest readout is enabled by defining HASH_STATE_SERIAL_OUT_EN.
module hash_state_bank #(
    parameter int WIDTH  = 32,
    parameter int NWORDS = 8,
    parameter int ROUNDS = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     init,
    input  logic [NWORDS*WIDTH-1:0]  iv,
    input  logic                     soc,
    input  logic                     round_en,
    input  logic [NWORDS*WIDTH-1:0]  round_in,
    input  logic                     eoc,
    input  logic                     rd_start,
    output logic [NWORDS*WIDTH-1:0]  h_out,
    output logic [NWORDS*WIDTH-1:0]  w_out,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    output logic                     dout_last
);

    localparam int CW = $clog2(ROUNDS + 1);
    localparam logic [CW-1:0] ROUNDS_C = CW'(ROUNDS);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_COMPRESS = 3'd1;
    localparam logic [2:0] S_ACCUM    = 3'd2;
    localparam logic [2:0] S_DONE     = 3'd3;
    localparam logic [2:0] S_READOUT  = 3'd4;

    logic [2:0]       state;
    logic [WIDTH-1:0] h_q [NWORDS];
    logic [WIDTH-1:0] w_q [NWORDS];
    logic [CW-1:0]    round_cnt;
    logic [CW-1:0]    cnt_next;
    logic             h_valid;
    logic             err_q;
    logic             done_q;
    logic             rd_go;
    logic             rd_end;
    logic             round_take;

    // A round beyond the expected count is dropped rather than captured.
    assign round_take = round_en && (round_cnt != ROUNDS_C);
    assign cnt_next   = round_take ? round_cnt + CW'(1) : round_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            round_cnt <= '0;
            h_valid   <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            for (int unsigned i = 0; i < NWORDS; i++) begin
                h_q[i] <= '0;
                w_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (init) begin
                        for (int unsigned i = 0; i < NWORDS; i++) begin
                            h_q[i] <= iv[(NWORDS-1-i)*WIDTH +: WIDTH];
                            w_q[i] <= '0;
                        end
                        round_cnt <= '0;
                        h_valid   <= 1'b1;
                        err_q     <= 1'b0;
                        state     <= S_IDLE;
                    end else if (soc && h_valid) begin
                        // H is undefined after reset, so a compression may only start once init has loaded it.
                        for (int unsigned i = 0; i < NWORDS; i++) begin
                            w_q[i] <= h_q[i];
                        end
                        round_cnt <= '0;
                        state     <= S_COMPRESS;
                    end else if (rd_go) begin
                        state <= S_READOUT;
                    end
                end
                S_COMPRESS: begin
                    if (round_en) begin
                        if (round_take) begin
                            for (int unsigned i = 0; i < NWORDS; i++) begin
                                w_q[i] <= round_in[(NWORDS-1-i)*WIDTH +: WIDTH];
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                        round_cnt <= cnt_next;
                    end
                    if (eoc) begin
                        if (cnt_next != ROUNDS_C) begin
                            err_q <= 1'b1;
                        end
                        state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    for (int unsigned i = 0; i < NWORDS; i++) begin
                        h_q[i] <= h_q[i] + w_q[i];
                    end
                    done_q <= 1'b1;
                    state  <= S_DONE;
                end
                S_READOUT: begin
                    if (rd_end) begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        h_out = '0;
        w_out = '0;
        for (int unsigned i = 0; i < NWORDS; i++) begin
            h_out[(NWORDS-1-i)*WIDTH +: WIDTH] = h_q[i];
            w_out[(NWORDS-1-i)*WIDTH +: WIDTH] = w_q[i];
        end
    end

    assign busy = (state == S_COMPRESS) || (state == S_ACCUM) || (state == S_READOUT);
    assign done = done_q;
    assign err  = err_q;

`ifdef HASH_STATE_SERIAL_OUT_EN
    localparam int RW = $clog2(NWORDS + 1);
    localparam logic [RW-1:0] NWORDS_C = RW'(NWORDS);

    logic [RW-1:0]    rd_idx;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] dout_q;
    logic             dv_q;
    logic             dl_q;

    assign rd_go  = (state == S_DONE) && rd_start && !init && !soc;
    assign rd_end = (state == S_READOUT) && (rd_idx == NWORDS_C);

    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < NWORDS; i++) begin
            if (RW'(i) == rd_idx) begin
                rd_word = h_q[i];
            end
        end
    end

    // rd_idx points at the next word to present; it reaches NWORDS one cycle after the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx <= '0;
            dout_q <= '0;
            dv_q   <= 1'b0;
            dl_q   <= 1'b0;
        end else if (rd_go) begin
            dout_q <= h_q[0];
            dv_q   <= 1'b1;
            dl_q   <= (NWORDS == 1);
            rd_idx <= RW'(1);
        end else if ((state == S_READOUT) && !rd_end) begin
            dout_q <= rd_word;
            dv_q   <= 1'b1;
            dl_q   <= (rd_idx == NWORDS_C - RW'(1));
            rd_idx <= rd_idx + RW'(1);
        end else begin
            rd_idx <= '0;
            dout_q <= '0;
            dv_q   <= 1'b0;
            dl_q   <= 1'b0;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign dout_last  = dl_q;
`else
    logic unused_rd_start;

    assign unused_rd_start = rd_start;
    assign rd_go           = 1'b0;
    assign rd_end          = 1'b0;
    assign dout            = '0;
    assign dout_valid      = 1'b0;
    assign dout_last       = 1'b0;
`endif

endmodule

// File: tb/tb_hash_state_bank.sv
// Randomized self-checking bench for hash_state_bank against a word-level model of H, W, round count and err.
module tb_hash_state_bank;
    localparam int W  = 32;
    localparam int N  = 8;
    localparam int R  = 64;
    localparam int PW = W * N;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init = 1'b0;
    logic          soc = 1'b0;
    logic          round_en = 1'b0;
    logic          eoc = 1'b0;
    logic          rd_start = 1'b0;
    logic [PW-1:0] iv = '0;
    logic [PW-1:0] round_in = '0;
    logic [PW-1:0] h_out;
    logic [PW-1:0] w_out;
    logic          busy;
    logic          done;
    logic          err;
    logic [W-1:0]  dout;
    logic          dout_valid;
    logic          dout_last;

    int tests_run = 0;
    int fails = 0;
    int done_cnt = 0;

    logic [W-1:0] mh [N];
    logic [W-1:0] mw [N];
    logic         merr;
    int           mcnt;

    hash_state_bank #(.WIDTH(W), .NWORDS(N), .ROUNDS(R)) dut (
        .clk(clk), .rst_n(rst_n), .init(init), .iv(iv), .soc(soc),
        .round_en(round_en), .round_in(round_in), .eoc(eoc), .rd_start(rd_start),
        .h_out(h_out), .w_out(w_out), .busy(busy), .done(done), .err(err),
        .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] pack_h();
        logic [PW-1:0] v = '0;
        for (int i = 0; i < N; i++) v[(N-1-i)*W +: W] = mh[i];
        return v;
    endfunction

    function automatic logic [PW-1:0] pack_w();
        logic [PW-1:0] v = '0;
        for (int i = 0; i < N; i++) v[(N-1-i)*W +: W] = mw[i];
        return v;
    endfunction

    function automatic logic [PW-1:0] rand_vec();
        logic [PW-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i*W +: W] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mh[i] = '0;
            mw[i] = '0;
        end
        merr = 1'b0;
        mcnt = 0;
    endtask

    task automatic do_init(input logic [PW-1:0] v);
        iv = v;
        init = 1'b1;
        step();
        init = 1'b0;
        for (int i = 0; i < N; i++) begin
            mh[i] = v[(N-1-i)*W +: W];
            mw[i] = '0;
        end
        merr = 1'b0;
        mcnt = 0;
    endtask

    // Drive one round cycle; the model applies the capture/overflow rule directly.
    task automatic drive_round(input logic [PW-1:0] rin, input bit with_eoc);
        round_en = 1'b1;
        round_in = rin;
        eoc = with_eoc;
        step();
        round_en = 1'b0;
        eoc = 1'b0;
        if (mcnt == R) merr = 1'b1;
        else begin
            for (int i = 0; i < N; i++) mw[i] = rin[(N-1-i)*W +: W];
            mcnt++;
        end
    endtask

    // One full block from soc to the cycle after done; nr rounds, optionally merging the last with eoc.
    task automatic run_block(input string name, input int nr, input bit merge,
                             input bit fixed, input logic [W-1:0] fval, input bit poke_init);
        logic [PW-1:0] rin;
        int            dstart;
        soc = 1'b1;
        step();
        soc = 1'b0;
        for (int i = 0; i < N; i++) mw[i] = mh[i];
        mcnt = 0;
        tests_run++;
        if (busy !== 1'b1 || w_out !== pack_w()) begin
            fails++;
            $display("FAIL %s_start busy=%b w_out=%h expected busy=1 w_out=%h", name, busy, w_out, pack_w());
        end
        for (int r = 0; r < nr; r++) begin
            if (fixed) for (int i = 0; i < N; i++) rin[i*W +: W] = fval;
            else rin = rand_vec();
            if (poke_init && r == 5) begin
                init = 1'b1;
                iv = rand_vec();
            end
            drive_round(rin, merge && (r == nr - 1));
            init = 1'b0;
        end
        if (!merge) begin
            eoc = 1'b1;
            step();
            eoc = 1'b0;
        end
        if (mcnt != R) merr = 1'b1;
        dstart = done_cnt;
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL %s_accum busy=%b done=%b expected busy=1 done=0", name, busy, done);
        end
        step();
        for (int i = 0; i < N; i++) mh[i] = mh[i] + mw[i];
        tests_run++;
        if (h_out !== pack_h() || err !== merr || done !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_result h_out=%h err=%b done=%b busy=%b expected h_out=%h err=%b done=1 busy=0",
                     name, h_out, err, done, busy, pack_h(), merr);
        end
        step();
        tests_run++;
        if (done !== 1'b0 || done_cnt - dstart != 1) begin
            fails++;
            $display("FAIL %s_done_pulse done=%b pulses=%0d expected done=0 pulses=1", name, done, done_cnt - dstart);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        model_reset();
        tests_run++;
        if (h_out !== '0 || w_out !== '0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || dout_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset h=%h w=%h busy=%b done=%b err=%b dv=%b expected all zero", h_out, w_out, busy, done, err, dout_valid);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_init();
        logic [PW-1:0] sha_iv;
        sha_iv = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        do_init(sha_iv);
        tests_run++;
        if (h_out !== sha_iv || w_out !== '0 || err !== 1'b0) begin
            fails++;
            $display("FAIL init h_out=%h w_out=%h err=%b expected h_out=%h w_out=0 err=0", h_out, w_out, err, sha_iv);
        end
    endtask

    task automatic test_wrap();
        do_init('1);
        run_block("wrap", R, 1'b0, 1'b1, 32'h2, 1'b0);
        tests_run++;
        if (h_out !== {N{32'h00000001}} || err !== 1'b0) begin
            fails++;
            $display("FAIL wrap_value h_out=%h err=%b expected all words 00000001 err=0", h_out, err);
        end
    endtask

    task automatic test_short();
        do_init('1);
        run_block("short", R - 1, 1'b0, 1'b1, 32'h2, 1'b0);
        soc = 1'b1;
        step();
        soc = 1'b0;
        step();
        tests_run++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL short_sticky err=%b expected 1", err);
        end
        eoc = 1'b1;
        step();
        eoc = 1'b0;
        step();
        step();
        do_init('1);
        tests_run++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL short_clear err=%b expected 0", err);
        end
    endtask

    task automatic test_same_cycle();
        do_init(rand_vec());
        run_block("merge", R, 1'b1, 1'b0, '0, 1'b0);
        do_init(rand_vec());
        run_block("overflow", R + 1, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_random_chain();
        do_init(rand_vec());
        for (int b = 0; b < 6; b++) begin
            run_block("chain", $urandom_range(R - 2, R + 2), bit'($urandom_range(0, 1)), 1'b0, '0, b == 2);
        end
    endtask

    task automatic test_reset_mid();
        do_init(rand_vec());
        soc = 1'b1;
        step();
        soc = 1'b0;
        for (int r = 0; r < 10; r++) drive_round(rand_vec(), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        tests_run++;
        if (h_out !== '0 || w_out !== '0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || dout_valid !== 1'b0) begin
            fails++;
            $display("FAIL midreset h=%h w=%h busy=%b done=%b err=%b dv=%b expected all zero", h_out, w_out, busy, done, err, dout_valid);
        end
        step();
        rst_n = 1'b1;
        soc = 1'b1;
        step();
        soc = 1'b0;
        step();
        tests_run++;
        if (busy !== 1'b0 || h_out !== '0 || w_out !== '0) begin
            fails++;
            $display("FAIL midreset_soc busy=%b h=%h w=%h expected busy=0 h=0 w=0", busy, h_out, w_out);
        end
        do_init(rand_vec());
        run_block("after_reset", R, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_readout();
        logic [PW-1:0] wsave;
        do_init(rand_vec());
        run_block("pre_read", R, 1'b0, 1'b0, '0, 1'b0);
        wsave = w_out;
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
`ifdef HASH_STATE_SERIAL_OUT_EN
        for (int i = 0; i < N; i++) begin
            tests_run++;
            if (dout_valid !== 1'b1 || dout !== mh[i] || dout_last !== (i == N - 1) || busy !== 1'b1) begin
                fails++;
                $display("FAIL readout_word%0d dv=%b dout=%h last=%b busy=%b expected dv=1 dout=%h last=%b busy=1",
                         i, dout_valid, dout, dout_last, busy, mh[i], i == N - 1);
            end
            soc = (i == 2);
            init = (i == 4);
            step();
            soc = 1'b0;
            init = 1'b0;
        end
        tests_run++;
        if (dout_valid !== 1'b0 || busy !== 1'b0 || w_out !== wsave || h_out !== pack_h()) begin
            fails++;
            $display("FAIL readout_end dv=%b busy=%b w=%h h=%h expected dv=0 busy=0 w=%h h=%h",
                     dout_valid, busy, w_out, h_out, wsave, pack_h());
        end
        run_block("post_read", R, 1'b0, 1'b0, '0, 1'b0);
`else
        for (int i = 0; i < N + 2; i++) begin
            tests_run++;
            if (dout_valid !== 1'b0 || dout_last !== 1'b0 || dout !== '0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL no_readout cycle%0d dv=%b last=%b dout=%h busy=%b expected all zero", i, dout_valid, dout_last, dout, busy);
            end
            step();
        end
        tests_run++;
        if (w_out !== wsave) begin
            fails++;
            $display("FAIL no_readout_w w=%h expected %h", w_out, wsave);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_init();
        test_wrap();
        test_short();
        test_same_cycle();
        test_random_chain();
        test_reset_mid();
        test_readout();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1);
    end
endmodule
